// File: rtl/infer_ctrl.sv
// Inference run sequencer: debounced key / external request -> settle delay -> CNN start,
// then wait for done under a timeout, latch and compare the class, hold the match LED.
module infer_ctrl #(
    parameter int DEBOUNCE    = 1000,
    parameter int START_DELAY = 1000,
    parameter int TIMEOUT     = 16777215,
    parameter int LED_HOLD    = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_n,
    input  logic        ext_start,
    input  logic [3:0]  expected,
    input  logic        cnn_done,
    input  logic [3:0]  cnn_result,
    output logic        cnn_start,
    output logic        busy,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic        match_led,
    output logic        timeout_err,
    output logic [15:0] run_count
);

    localparam int DBW = (DEBOUNCE    > 1) ? $clog2(DEBOUNCE)    : 1;
    localparam int SDW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int TOW = (TIMEOUT     > 1) ? $clog2(TIMEOUT)     : 1;
    localparam int LHW = (LED_HOLD    > 1) ? $clog2(LED_HOLD)    : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [SDW-1:0] SD_LAST = SDW'(START_DELAY - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
    localparam logic [LHW-1:0] LH_LAST = LHW'(LED_HOLD - 1);

    typedef enum logic [2:0] {IDLE, ARM, START, WAIT, SHOW} state_t;

    state_t         state;
    logic           key_s1, key_s2;
    logic           db_pressed;
    logic [DBW-1:0] db_cnt;
    logic [SDW-1:0] dly_cnt;
    logic [TOW-1:0] to_cnt;
    logic [LHW-1:0] hold_cnt;
    logic           req_q;
    logic           key_press;

    // The debouncer counts samples that disagree with its current state; any agreeing
    // sample restarts the count, so only an unbroken run of DEBOUNCE cycles flips it.
    assign key_press = !db_pressed && !key_s2 && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1     <= 1'b1;
            key_s2     <= 1'b1;
            db_pressed <= 1'b0;
            db_cnt     <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            if (key_s2 == db_pressed) begin
                if (db_cnt == DB_LAST) begin
                    db_pressed <= ~db_pressed;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            dly_cnt      <= '0;
            to_cnt       <= '0;
            hold_cnt     <= '0;
            cnn_start    <= 1'b0;
            busy         <= 1'b0;
            result       <= 4'd0;
            result_valid <= 1'b0;
            match_led    <= 1'b1;
            timeout_err  <= 1'b0;
            run_count    <= 16'd0;
        end else begin
            cnn_start    <= 1'b0;
            result_valid <= 1'b0;
            // Requests are only captured while idle, so anything arriving mid-run is dropped.
            req_q        <= (key_press || ext_start) && (state == IDLE);
            case (state)
                IDLE: begin
                    if (req_q) begin
                        state       <= ARM;
                        busy        <= 1'b1;
                        dly_cnt     <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                ARM: begin
                    if (dly_cnt == SD_LAST) begin
                        state     <= START;
                        cnn_start <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + SDW'(1);
                    end
                end
                START: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (cnn_done) begin
                        result       <= cnn_result;
                        result_valid <= 1'b1;
                        match_led    <= (cnn_result == expected) ? 1'b0 : 1'b1;
                        run_count    <= run_count + 16'd1;
                        hold_cnt     <= '0;
                        state        <= SHOW;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                SHOW: begin
                    if (hold_cnt == LH_LAST) begin
                        match_led <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + LHW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
